// File: rtl/gmii_pkg.sv
// Shared GMII transmit definitions: PCS xmit encodings, framing octets,
// scheduler states and the two-way round-robin pick helper.
package gmii_pkg;

  localparam logic [2:0] XMIT_CONFIGURATION = 3'b001;
  localparam logic [2:0] XMIT_IDLE          = 3'b010;
  localparam logic [2:0] XMIT_DATA          = 3'b100;

  localparam logic [7:0] PREAMBLE_OCTET = 8'h55;
  localparam logic [7:0] SFD_OCTET      = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    IPG
  } sched_state_t;

  // A lone requester wins outright; on a tie the one that did not own the
  // previous frame wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin selector. The last-grant register only moves
// when a frame actually starts, so arbitration is frame-by-frame.
module rr_arbiter2
  import gmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       sel,
  output logic       last_grant
);

  // Candidate winner for a frame starting this cycle.
  always_comb begin
    sel = rr_pick(req, last_grant);
  end

  // Last-grant register; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (take) begin
      last_grant <= sel;
    end
  end

endmodule

// File: rtl/gmii_tx_scheduler.sv
// GMII transmit scheduler: round-robin frame arbitration between two octet
// requesters, preamble/SFD framing, underrun signalling and inter-packet gap.
module gmii_tx_scheduler
  import gmii_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IPG_LEN      = 12
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset_n,
  input  logic [2:0] xmit,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [1:0] req_last,
  output logic [1:0] req_ready,
  output logic [7:0] TXD,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic       grant,
  output logic       busy
);

  localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN) + 1;
  localparam int unsigned IPG_W = $clog2(IPG_LEN) + 1;

  sched_state_t     state;
  logic [PRE_W-1:0] pre_cnt;
  logic [IPG_W-1:0] ipg_cnt;

  logic       start_ok;
  logic       frame_start;
  logic       arb_sel;
  logic       gnt_valid;
  logic       gnt_last;
  logic [7:0] gnt_data;

  // A new frame may begin from IDLE, or directly from the last IPG cycle so
  // back-to-back frames see exactly IPG_LEN idle cycles.
  always_comb begin
    start_ok    = (xmit == XMIT_DATA) && (req_valid != 2'b00);
    frame_start = start_ok &&
                  ((state == IDLE) ||
                   ((state == IPG) && (ipg_cnt == IPG_W'(IPG_LEN))));
  end

  rr_arbiter2 u_arb (
    .clk        (GTX_CLK),
    .rst_n      (mr_main_reset_n),
    .req        (req_valid),
    .take       (frame_start),
    .sel        (arb_sel),
    .last_grant (grant)
  );

  // Granted requester's octet stream.
  always_comb begin
    gnt_valid = req_valid[grant];
    gnt_last  = req_last[grant];
    gnt_data  = grant ? req_data1 : req_data0;
  end

  // Only the granted requester is ever acknowledged, and only in DATA.
  always_comb begin
    req_ready = '0;
    if (state == DATA) begin
      req_ready[grant] = gnt_valid;
    end
  end

  // Framing FSM. The state register leads the GMII outputs by one cycle:
  // each state decides what is driven next, so the first payload octet is
  // accepted while the SFD is on the wire and follows it without a bubble.
  always_ff @(posedge GTX_CLK or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state   <= IDLE;
      TXD     <= '0;
      TX_EN   <= 1'b0;
      TX_ER   <= 1'b0;
      busy    <= 1'b0;
      pre_cnt <= '0;
      ipg_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          TXD   <= '0;
          TX_EN <= 1'b0;
          TX_ER <= 1'b0;
          busy  <= 1'b0;
          if (frame_start) begin
            state   <= (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
            TXD     <= PREAMBLE_OCTET;
            TX_EN   <= 1'b1;
            busy    <= 1'b1;
            pre_cnt <= PRE_W'(1);
          end
        end

        PREAMBLE: begin
          TXD     <= PREAMBLE_OCTET;
          TX_EN   <= 1'b1;
          TX_ER   <= 1'b0;
          pre_cnt <= pre_cnt + 1'b1;
          if (pre_cnt == PRE_W'(PREAMBLE_LEN - 1)) begin
            state <= SFD;
          end
        end

        SFD: begin
          TXD   <= SFD_OCTET;
          TX_EN <= 1'b1;
          TX_ER <= 1'b0;
          state <= DATA;
        end

        DATA: begin
          TX_EN <= 1'b1;
          if (gnt_valid) begin
            TXD   <= gnt_data;
            TX_ER <= 1'b0;
            if (gnt_last) begin
              state   <= IPG;
              busy    <= 1'b0;
              ipg_cnt <= '0;
            end
          end else begin
            TXD   <= '0;
            TX_ER <= 1'b1;
          end
        end

        IPG: begin
          TXD   <= '0;
          TX_EN <= 1'b0;
          TX_ER <= 1'b0;
          if (ipg_cnt == IPG_W'(IPG_LEN)) begin
            if (frame_start) begin
              state   <= (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
              TXD     <= PREAMBLE_OCTET;
              TX_EN   <= 1'b1;
              busy    <= 1'b1;
              pre_cnt <= PRE_W'(1);
            end else begin
              state <= IDLE;
            end
          end else begin
            ipg_cnt <= ipg_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          TXD   <= '0;
          TX_EN <= 1'b0;
          TX_ER <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Scoreboard bench for gmii_tx_scheduler: expected wire octets and frame
// grants are queued as frames are loaded and checked as TX_EN activity appears.
module tb_gmii_tx_scheduler;
  import gmii_pkg::*;

  localparam int PRE = 7;
  localparam int IPG_CYC = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] xmit;
  logic [1:0] req_valid = '0;
  logic [7:0] req_data0 = '0;
  logic [7:0] req_data1 = '0;
  logic [1:0] req_last = '0;
  logic [1:0] req_ready;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic       grant;
  logic       busy;

  gmii_tx_scheduler #(
    .PREAMBLE_LEN (PRE),
    .IPG_LEN      (IPG_CYC)
  ) dut (
    .GTX_CLK         (clk),
    .mr_main_reset_n (rst_n),
    .xmit            (xmit),
    .req_valid       (req_valid),
    .req_data0       (req_data0),
    .req_data1       (req_data1),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .TXD             (TXD),
    .TX_EN           (TX_EN),
    .TX_ER           (TX_ER),
    .grant           (grant),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Requester source queues: {last, data}
  logic [8:0] rq0[$];
  logic [8:0] rq1[$];
  // Scoreboard: wire octets {TX_ER, TXD}, frame owners, gap-check flags
  logic [8:0] exp_q[$];
  int         exp_grant[$];
  bit         exp_gap[$];

  int pause_after0 = -1;
  int sent0        = 0;
  int pause_cnt0   = 0;
  int rdy0_cycles  = 0;

  // Requester model: present the queue head, accept on ready.
  always begin
    logic [1:0] acc;
    @(negedge clk);
    req_valid[0] = (rq0.size() != 0) && (pause_cnt0 == 0);
    req_data0    = (rq0.size() != 0) ? rq0[0][7:0] : 8'h00;
    req_last[0]  = (rq0.size() != 0) ? rq0[0][8] : 1'b0;
    req_valid[1] = (rq1.size() != 0);
    req_data1    = (rq1.size() != 0) ? rq1[0][7:0] : 8'h00;
    req_last[1]  = (rq1.size() != 0) ? rq1[0][8] : 1'b0;
    #3;
    acc = req_ready & req_valid;
    if (req_ready[0]) rdy0_cycles++;
    check_eq("ready_ungranted", 32'(req_ready & ~(2'b01 << grant)), 32'd0);
    @(posedge clk);
    if (acc[0]) begin
      void'(rq0.pop_front());
      sent0++;
      if (sent0 == pause_after0) pause_cnt0 = 2;
    end else if (pause_cnt0 != 0) begin
      pause_cnt0--;
    end
    if (acc[1]) void'(rq1.pop_front());
  end

  // Wire monitor.
  logic prev_en = 1'b0;
  int   gap_cnt = 0;
  always @(negedge clk) begin
    int g;
    bit gc;
    if (TX_EN) begin
      if (!prev_en) begin
        if (exp_grant.size() == 0) begin
          check_eq("frame_unexpected", 32'(TX_EN), 32'd0);
        end else begin
          g  = exp_grant.pop_front();
          gc = exp_gap.pop_front();
          check_eq("grant", 32'(grant), 32'(g));
          if (gc) check_eq("ipg_gap", 32'(gap_cnt), 32'(IPG_CYC));
        end
      end
      if (exp_q.size() == 0) check_eq("octet_unexpected", 32'(TX_EN), 32'd0);
      else check_eq("octet", 32'({TX_ER, TXD}), 32'(exp_q.pop_front()));
      gap_cnt = 0;
    end else begin
      gap_cnt++;
      check_eq("idle_octet", 32'({TX_ER, TXD}), 32'd0);
    end
    prev_en = TX_EN;
  end

  task automatic push_frame(input int r, input logic [7:0] base, input int n,
                            input bit gap_chk, input int under_after);
    logic [7:0] b;
    exp_grant.push_back(r);
    exp_gap.push_back(gap_chk);
    for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, PREAMBLE_OCTET});
    exp_q.push_back({1'b0, SFD_OCTET});
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i * 17);
      if (r == 0) rq0.push_back({(i == n - 1), b});
      else        rq1.push_back({(i == n - 1), b});
      exp_q.push_back({1'b0, b});
      if (i + 1 == under_after) begin
        exp_q.push_back(9'h100);
        exp_q.push_back(9'h100);
      end
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
    check_eq("en_after_frame", 32'(TX_EN), 32'd0);
  endtask

  initial begin
    int en_cnt;
    int waited;
    rst_n = 1'b0;
    xmit  = XMIT_DATA;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_txd",   32'(TXD), 32'd0);
    check_eq("rst_en_er", 32'({TX_EN, TX_ER}), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd1);
    check_eq("rst_busy",  32'(busy), 32'd0);
    rst_n = 1'b1;

    // Back-to-back 2-octet frames from both requesters: 0,1,0,1
    push_frame(0, 8'hA0, 2, 1'b0, -1);
    push_frame(1, 8'hB0, 2, 1'b1, -1);
    push_frame(0, 8'hC0, 2, 1'b1, -1);
    push_frame(1, 8'hE0, 2, 1'b1, -1);
    wait_drain(200);

    // Single 4-octet frame 11,22,33,44 from requester 0
    rdy0_cycles = 0;
    push_frame(0, 8'h11, 4, 1'b0, -1);
    wait_drain(100);
    check_eq("ready0_cycles", 32'(rdy0_cycles), 32'd4);

    // xmit=IDLE holds off requester 1; preamble starts right after DATA
    xmit = XMIT_IDLE;
    push_frame(1, 8'h31, 3, 1'b0, -1);
    en_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (TX_EN) en_cnt++;
    end
    check_eq("xmit_idle_hold", 32'(en_cnt), 32'd0);
    xmit = XMIT_DATA;
    @(negedge clk); #1;
    check_eq("preamble_next_cycle", 32'({TX_EN, TXD}), 32'({1'b1, PREAMBLE_OCTET}));
    wait_drain(100);

    // Requester 0 underruns for two cycles after octet 2
    sent0 = 0;
    pause_after0 = 2;
    push_frame(0, 8'h41, 5, 1'b0, 2);
    wait_drain(100);
    pause_after0 = -1;

    // xmit leaves DATA mid-frame: frame completes, next frame gated
    push_frame(0, 8'h51, 6, 1'b0, -1);
    waited = 0;
    while (!busy && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("busy_seen", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    xmit = XMIT_CONFIGURATION;
    push_frame(1, 8'h71, 3, 1'b0, -1);
    waited = 0;
    while (exp_q.size() > PRE + 1 + 3 && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("cfg_frame_done", 32'(exp_q.size()), 32'(PRE + 1 + 3));
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (TX_EN) en_cnt++;
    end
    check_eq("xmit_cfg_hold", 32'(en_cnt), 32'd0);
    xmit = XMIT_DATA;
    wait_drain(100);

    // Reset pulse mid-payload
    push_frame(0, 8'h61, 6, 1'b0, -1);
    waited = 0;
    while (!(TX_EN && TXD == 8'h83) && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("reached_payload", 32'(TXD), 32'h83);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_en_er", 32'({TX_EN, TX_ER}), 32'd0);
    check_eq("mid_rst_txd",   32'(TXD), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    exp_grant.delete();
    exp_gap.delete();
    rq0.delete();
    rq1.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("grant_after_reset", 32'(grant), 32'd1);
    push_frame(0, 8'h91, 2, 1'b0, -1);
    push_frame(1, 8'hA1, 2, 1'b1, -1);
    wait_drain(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
